// File: rtl/agc_ctrl_pkg.sv
// Shared definitions for the AGC lock controller: FSM state encoding and
// constant helpers used to size gains and counters.
package agc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic int unsigned unity_gain(input int unsigned gain_point);
    return 32'd1 << gain_point;
  endfunction

  // Counters must hold the larger of the two terminal counts without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/agc_lock_detect.sv
// Convergence detector: tracks successive AGC gain deltas, counting consecutive
// settled updates and total updates during acquisition.
module agc_lock_detect
  import agc_ctrl_pkg::*;
#(
  parameter int GAIN_WIDTH  = 12,
  parameter int GAIN_POINT  = 10,
  parameter int LOCK_TOL    = 4,
  parameter int LOCK_COUNT  = 8,
  parameter int ACQ_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  reload,
  input  logic                  upd,
  input  logic [GAIN_WIDTH-1:0] gain,
  output logic                  settle_done,
  output logic                  timeout_done
);

  localparam int CNT_W = int'(cnt_width(LOCK_COUNT, ACQ_TIMEOUT));
  localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]      LOCK_CNT  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]      TIMEO_CNT = CNT_W'(ACQ_TIMEOUT);
  localparam logic [GAIN_WIDTH-1:0] UNITY     = GAIN_WIDTH'(unity_gain(GAIN_POINT));
  localparam logic [GAIN_WIDTH:0]   TOL       = (GAIN_WIDTH+1)'(LOCK_TOL);

  logic [GAIN_WIDTH-1:0] prev_gain_q, prev_gain_d;
  logic [CNT_W-1:0]      settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]      upd_cnt_q, upd_cnt_d;

  logic signed [GAIN_WIDTH:0] diff;
  logic [GAIN_WIDTH:0]        diff_abs;
  logic                       settled;
  logic [CNT_W-1:0]           settle_inc;
  logic [CNT_W-1:0]           upd_inc;

  // One extra bit keeps the unsigned difference from overflowing before abs.
  assign diff     = $signed({1'b0, gain}) - $signed({1'b0, prev_gain_q});
  assign diff_abs = diff[GAIN_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign settled  = (diff_abs <= TOL);

  assign settle_inc = !settled                ? '0 :
                      (settle_cnt_q == CNT_MAX) ? settle_cnt_q :
                      settle_cnt_q + CNT_W'(1);
  assign upd_inc    = (upd_cnt_q == CNT_MAX) ? upd_cnt_q : upd_cnt_q + CNT_W'(1);

  // Terminal flags reflect the update being applied this cycle.
  assign settle_done  = upd & (settle_inc >= LOCK_CNT);
  assign timeout_done = upd & (upd_inc >= TIMEO_CNT);

  always_comb begin
    prev_gain_d  = prev_gain_q;
    settle_cnt_d = settle_cnt_q;
    upd_cnt_d    = upd_cnt_q;
    if (clr) begin
      prev_gain_d  = UNITY;
      settle_cnt_d = '0;
      upd_cnt_d    = '0;
    end else if (reload) begin
      prev_gain_d  = gain;
      settle_cnt_d = '0;
      upd_cnt_d    = '0;
    end else if (upd) begin
      prev_gain_d  = gain;
      settle_cnt_d = settle_inc;
      upd_cnt_d    = upd_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_gain_q  <= UNITY;
      settle_cnt_q <= '0;
      upd_cnt_q    <= '0;
    end else begin
      prev_gain_q  <= prev_gain_d;
      settle_cnt_q <= settle_cnt_d;
      upd_cnt_q    <= upd_cnt_d;
    end
  end

endmodule

// File: rtl/agc_lock_ctrl.sv
// AGC sequencing controller: starts/clears the AGC, gates its sample stream,
// freezes the applied gain once converged and watches for loss of lock.
module agc_lock_ctrl
  import agc_ctrl_pkg::*;
#(
  parameter int GAIN_WIDTH  = 12,
  parameter int GAIN_POINT  = 10,
  parameter int LOCK_TOL    = 4,
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_TOL  = 64,
  parameter int ACQ_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  freeze,
  input  logic                  din_valid,
  output logic                  agc_din_valid,
  output logic                  agc_clear,
  input  logic [GAIN_WIDTH-1:0] agc_gain,
  input  logic                  agc_gain_valid,
  output logic [GAIN_WIDTH-1:0] gain_out,
  output logic                  gain_out_valid,
  output logic                  locked,
  output logic                  busy,
  output logic                  acq_timeout,
  output logic                  lock_lost
);

  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(unity_gain(GAIN_POINT));
  localparam logic [GAIN_WIDTH:0]   UTOL  = (GAIN_WIDTH+1)'(UNLOCK_TOL);

  state_e state_q, state_d;

  logic [GAIN_WIDTH-1:0] gain_out_q, gain_out_d;
  logic [GAIN_WIDTH-1:0] locked_gain_q, locked_gain_d;
  logic gain_out_valid_q, gain_out_valid_d;
  logic locked_q, locked_d;
  logic busy_q, busy_d;
  logic acq_timeout_q, acq_timeout_d;
  logic lock_lost_q, lock_lost_d;
  logic agc_clear_q, agc_clear_d;

  logic gain_upd, acq_upd, unlock_hit;
  logic go_lock, lost_evt, timeout_evt;
  logic settle_done, timeout_done;
  logic signed [GAIN_WIDTH:0] unlock_diff;
  logic [GAIN_WIDTH:0]        unlock_abs;

  // A gain strobe alongside agc_clear still carries the pre-clear gain.
  assign gain_upd    = agc_gain_valid & ~agc_clear_q;
  assign acq_upd     = gain_upd & (state_q == ST_ACQUIRE);
  assign unlock_diff = $signed({1'b0, agc_gain}) - $signed({1'b0, locked_gain_q});
  assign unlock_abs  = unlock_diff[GAIN_WIDTH] ? $unsigned(-unlock_diff) : $unsigned(unlock_diff);
  assign unlock_hit  = gain_upd & ~freeze & (state_q == ST_LOCKED) & (unlock_abs > UTOL);

  agc_lock_detect #(
    .GAIN_WIDTH (GAIN_WIDTH),
    .GAIN_POINT (GAIN_POINT),
    .LOCK_TOL   (LOCK_TOL),
    .LOCK_COUNT (LOCK_COUNT),
    .ACQ_TIMEOUT(ACQ_TIMEOUT)
  ) u_detect (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_d == ST_IDLE),
    .reload      (lost_evt),
    .upd         (acq_upd),
    .gain        (agc_gain),
    .settle_done (settle_done),
    .timeout_done(timeout_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (settle_done)       state_d = ST_LOCKED;
        else if (timeout_done) state_d = ST_IDLE;
      end
      ST_LOCKED: begin
        if (unlock_hit) state_d = ST_ACQUIRE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
  end

  assign go_lock     = (state_q == ST_ACQUIRE) & (state_d == ST_LOCKED);
  assign lost_evt    = (state_q == ST_LOCKED) & (state_d == ST_ACQUIRE);
  assign timeout_evt = (state_q == ST_ACQUIRE) & ~stop & timeout_done & ~settle_done;

  always_comb begin
    gain_out_d = gain_out_q;
    if (state_d == ST_IDLE) begin
      gain_out_d = UNITY;
    end else if (acq_upd) begin
      gain_out_d = agc_gain;
    end
    locked_gain_d    = go_lock ? agc_gain : locked_gain_q;
    gain_out_valid_d = (gain_out_d != gain_out_q);
    agc_clear_d      = (state_q == ST_IDLE) & start & ~stop;
    locked_d         = (state_d == ST_LOCKED);
    busy_d           = (state_d != ST_IDLE);
    acq_timeout_d    = timeout_evt;
    lock_lost_d      = lost_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gain_out_q       <= UNITY;
      locked_gain_q    <= UNITY;
      gain_out_valid_q <= 1'b0;
      agc_clear_q      <= 1'b0;
      locked_q         <= 1'b0;
      busy_q           <= 1'b0;
      acq_timeout_q    <= 1'b0;
      lock_lost_q      <= 1'b0;
    end else begin
      gain_out_q       <= gain_out_d;
      locked_gain_q    <= locked_gain_d;
      gain_out_valid_q <= gain_out_valid_d;
      agc_clear_q      <= agc_clear_d;
      locked_q         <= locked_d;
      busy_q           <= busy_d;
      acq_timeout_q    <= acq_timeout_d;
      lock_lost_q      <= lock_lost_d;
    end
  end

  // Gating must be zero-latency, so this output bypasses the output registers.
  assign agc_din_valid  = din_valid & (state_q != ST_IDLE);
  assign agc_clear      = agc_clear_q;
  assign gain_out       = gain_out_q;
  assign gain_out_valid = gain_out_valid_q;
  assign locked         = locked_q;
  assign busy           = busy_q;
  assign acq_timeout    = acq_timeout_q;
  assign lock_lost      = lock_lost_q;

endmodule
